// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared widths, encodings and hazard compare helper
package hazard_stall_ctrl_pkg;

  localparam int T_W = 2;
  typedef logic [T_W-1:0] t_cnt_t;

  localparam t_cnt_t TUSE_NONE  = 2'd3;
  localparam t_cnt_t TNEW_READY = 2'd0;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int MD_CNT_W        = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // One producer/consumer pair: stall only if the value cannot be forwarded in time.
  function automatic logic reg_hazard(input logic [4:0] src, input t_cnt_t tuse,
                                      input logic [4:0] a3, input t_cnt_t tnew);
    return (src != REG_ZERO) && (src == a3) && (tuse != TUSE_NONE) &&
           (tnew != TNEW_READY) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_tracker.sv
// rtl/hazard_stall_ctrl_md_busy_tracker.sv - mult/div busy countdown
module hazard_stall_ctrl_md_busy_tracker
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_E,
  input  logic md_is_div_E,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] LP_MULT = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] LP_DIV  = MD_CNT_W'(DIV_CYCLES);

  logic [MD_CNT_W-1:0] r_md_cnt;

  // A start while already counting is ignored; the running count keeps draining.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_md_cnt <= '0;
    end else if (md_start_E && (r_md_cnt == '0)) begin
      r_md_cnt <= md_is_div_E ? LP_DIV : LP_MULT;
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - MD_CNT_W'(1);
    end
  end

  assign md_busy = md_start_E | (r_md_cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline stall/flush decision and stall-cycle counter
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic [1:0]       Tuse_rs_D,
  input  logic [1:0]       Tuse_rt_D,
  input  logic [4:0]       A3_E,
  input  logic [1:0]       Tnew_E,
  input  logic [4:0]       A3_M,
  input  logic [1:0]       Tnew_M,
  input  logic             md_start_E,
  input  logic             md_is_div_E,
  input  logic             md_use_D,
  output logic             EN_F,
  output logic             EN_D,
  output logic             flush_E,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic w_stall_rs;
  logic w_stall_rt;
  logic w_md_stall;
  logic w_stall;
  logic [CNT_W-1:0] r_stall_cycles;

  hazard_stall_ctrl_md_busy_tracker #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy (
    .clk        (clk),
    .reset      (reset),
    .md_start_E (md_start_E),
    .md_is_div_E(md_is_div_E),
    .md_busy    (md_busy)
  );

  // E and M matches are ORed; either one alone is enough to hold D.
  assign w_stall_rs = reg_hazard(rs_D, Tuse_rs_D, A3_E, Tnew_E) |
                      reg_hazard(rs_D, Tuse_rs_D, A3_M, Tnew_M);
  assign w_stall_rt = reg_hazard(rt_D, Tuse_rt_D, A3_E, Tnew_E) |
                      reg_hazard(rt_D, Tuse_rt_D, A3_M, Tnew_M);
  assign w_md_stall = md_use_D & md_busy;
  assign w_stall    = w_stall_rs | w_stall_rt | w_md_stall;

  assign EN_F    = ~w_stall;
  assign EN_D    = ~w_stall;
  assign flush_E = w_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall and flush controller for the five-stage MIPS pipeline.
- Decides each cycle whether the IF/ID register may load (EN_D), whether the PC may advance (EN_F), and whether the ID/EX register must inject a bubble (flush_E).
- Combines Tuse/Tnew register-hazard detection with a multi-cycle mult/div busy tracker.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issues in E.
- DIV_CYCLES, 10, busy cycles after a div/divu issues in E.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rs_D  input  5  rs field of the instruction in D.
- rt_D  input  5  rt field of the instruction in D.
- Tuse_rs_D  input  2  cycles until D needs rs; 3 = not used.
- Tuse_rt_D  input  2  cycles until D needs rt; 3 = not used.
- A3_E  input  5  destination register of the instruction in E.
- Tnew_E  input  2  cycles until E result is forwardable; 0 = ready.
- A3_M  input  5  destination register of the instruction in M.
- Tnew_M  input  2  cycles until M result is forwardable.
- md_start_E  input  1  mult/div instruction is in E this cycle.
- md_is_div_E  input  1  1 = div/divu, 0 = mult/multu; valid with md_start_E.
- md_use_D  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- EN_F  output  1  PC write enable.
- EN_D  output  1  IF/ID register load enable.
- flush_E  output  1  clear the ID/EX register (bubble).
- md_busy  output  1  mult/div unit busy.
- stall_cycles  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- State: md_cnt (4 bits), stall_cycles (CNT_W bits). Both clear asynchronously when reset = 0.
- Reset values: md_cnt = 0, stall_cycles = 0, md_busy = 0.
- The stall outputs are combinational from inputs and state. They do not depend on reset; the state is cleared, so the outputs follow the current inputs.
- Data stall for rs: rs_D != 0 and either
  - rs_D == A3_E and Tnew_E > Tuse_rs_D, or
  - rs_D == A3_M and Tnew_M > Tuse_rs_D.
- Data stall for rt: identical condition with rt_D and Tuse_rt_D.
- Register $0 never stalls.
- Tuse = 3 never stalls, because Tnew is at most 2.
- md_busy = md_start_E | (md_cnt != 0).
- md_stall = md_use_D & md_busy.
- stall = data_stall_rs | data_stall_rt | md_stall.
- Enables: EN_F = EN_D = ~stall; flush_E = stall. Zero-cycle decision, no added latency.
- md_cnt update at a clock edge:
  - If md_start_E = 1 and md_cnt == 0: load DIV_CYCLES if md_is_div_E, else MULT_CYCLES.
  - Else if md_cnt != 0: decrement by 1.
  - Else: hold.
- md_start_E while md_cnt != 0 cannot occur legally, because md_stall blocks issue. If it does occur, the start is ignored and the count keeps decrementing.
- Busy window: after the start cycle, md_busy stays high for exactly MULT_CYCLES or DIV_CYCLES further cycles, then drops.
- stall_cycles: increments by 1 on each edge where stall = 1. It saturates at all-ones and never wraps.
- Reset asserted mid-operation: md_cnt and stall_cycles clear immediately, without waiting for a clock edge. md_busy drops in the same cycle unless md_start_E = 1.
- Simultaneous hazards in E and M on the same register both evaluate. Stall is their OR; E takes no priority because both conditions imply a stall.

Decomposition:
- Shared package holds:
  - Tnew/Tuse width and the encodings TUSE_NONE = 3 and TNEW_READY = 0.
  - MULT_CYCLES and DIV_CYCLES defaults.
  - REG_ZERO = 5'd0.
- Natural sub-module: md_busy_tracker, containing md_cnt, its load/decrement logic and md_busy.
- Hazard compare and performance counter stay in the top.

Test Plan:
- Load-use: A3_E = 8, Tnew_E = 2, rs_D = 8, Tuse_rs_D = 1.
  - Expect EN_F = EN_D = 0 and flush_E = 1 for 1 cycle.
  - Next cycle A3_M = 8, Tnew_M = 1: no stall; stall_cycles = 1.
- $0 and not-used: rs_D = 0 = A3_E with Tnew_E = 2 → no stall. rt_D = 9 = A3_E with Tuse_rt_D = 3 → no stall.
- Mult: md_start_E = 1, md_is_div_E = 0, then md_use_D = 1 held.
  - Expect md_busy high for the start cycle plus 5 cycles.
  - EN_D = 0 throughout that window; stall_cycles = 6; EN_D = 1 on the 7th cycle.
- Div: same sequence with md_is_div_E = 1.
  - Busy for start + 10 cycles.
  - An illegal md_start_E pulse mid-count does not reload the counter.
- Async reset: assert reset = 0 between clock edges while md_cnt = 4.
  - md_busy = 0 and stall_cycles = 0 before the next edge.
- Saturation: preload via a run with CNT_W = 4 and hold stall for 20 cycles.
  - stall_cycles = 15 and stays there.
